// File: rtl/flash_resp_pkg.sv
// Shared definitions for the flash word responder: FSM state encoding and
// word geometry (four bytes per word, little-endian).
package flash_resp_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_SEL_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

endpackage

// File: rtl/flash_resp_req_buf.sv
// Two-entry in-order request queue. Entry 0 is the active request being
// served, entry 1 is the pending request waiting behind it.
module flash_resp_req_buf #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] second_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] e0_q;
  logic [W-1:0] e1_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o   = (cnt_q == 2'd2);
  assign empty_o  = (cnt_q == 2'd0);
  assign head_o   = e0_q;
  assign second_o = e1_q;
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;

  // Queue storage and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_data_i;
          else               e1_q <= push_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= push_data_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/flash_responder.sv
// Word-read responder over a byte-wide backing memory. Each word request is
// split into four byte strobes and the returned bytes are packed
// little-endian into one response word.
// Optional build macro FLASH_RESP_CACHE_EN keeps the last returned word so a
// repeat read of the same address is answered without touching memory.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no active request
// ISSUE    | issuing byte strobes k=0..3 for the active request
// COLLECT  | all strobes taken, waiting for the remaining bytes
// RESPOND  | one-cycle valid with the assembled (or cached) word
module flash_responder
  import flash_resp_pkg::*;
#(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic              waitrequest,
  output logic              valid,
  output logic [31:0]       flash_data,
  output logic              mem_rd,
  output logic [ADDR_W+1:0] mem_addr,
  input  logic              mem_wait,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  input  logic              cache_flush
);

  state_e                state_q, state_d;
  logic [BYTE_SEL_W-1:0] k_q, k_d;
  logic [BYTE_SEL_W-1:0] rx_q, rx_d;
  logic [31:0]           word_q, word_d;
  logic [31:0]           data_q, data_d;

  logic [ADDR_W-1:0]     head_addr;
  logic [ADDR_W-1:0]     second_addr;
  logic                  buf_full;
  logic                  buf_empty;
  logic                  accept;
  logic                  pop;
  logic                  last_byte;
  logic [31:0]           fill_word;
  logic                  fill;
  logic [ADDR_W-1:0]     next_addr;
  logic                  hit;
  logic [31:0]           hit_data;

  assign accept    = read && !buf_full;
  assign pop       = (state_q == ST_RESPOND) && !buf_empty;
  assign last_byte = mem_rvalid && (rx_q == BYTE_SEL_W'(BYTES_PER_WORD - 1));
  assign fill_word = {mem_rdata, word_q[23:0]};
  // The request that becomes active next: a waiting pending entry wins over
  // one arriving on the bus this cycle.
  assign next_addr = (state_q == ST_RESPOND && buf_full) ? second_addr : address;

  flash_resp_req_buf #(.W(ADDR_W)) u_req_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (address),
    .pop_i       (pop),
    .head_o      (head_addr),
    .second_o    (second_addr),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

`ifdef FLASH_RESP_CACHE_EN
  logic              cvld_q, cvld_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [31:0]       cdata_q, cdata_d;

  // A flush in the same cycle as the lookup forces a miss.
  assign hit      = cvld_q && !cache_flush && (next_addr == caddr_q);
  assign hit_data = cdata_q;

  // Last-word cache update: refill on word completion, flush wins.
  always_comb begin
    cvld_d  = cvld_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    if (fill) begin
      cvld_d  = 1'b1;
      caddr_d = head_addr;
      cdata_d = fill_word;
    end
    if (cache_flush) cvld_d = 1'b0;
  end

  // Cache registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cvld_q  <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      cvld_q  <= cvld_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = cache_flush;
  assign hit          = 1'b0;
  assign hit_data     = '0;
`endif

  // FSM next state, strobe index, byte gathering and response word.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rx_d    = rx_q;
    word_d  = word_q;
    data_d  = data_q;
    fill    = 1'b0;

    if ((state_q == ST_ISSUE || state_q == ST_COLLECT) && mem_rvalid) begin
      word_d[{rx_q, 3'b000} +: 8] = mem_rdata;
      rx_d = rx_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        k_d  = '0;
        rx_d = '0;
        if (accept) begin
          state_d = hit ? ST_RESPOND : ST_ISSUE;
          if (hit) data_d = hit_data;
        end
      end
      ST_ISSUE: begin
        if (!mem_wait) begin
          k_d = k_q + 1'b1;
          if (k_q == BYTE_SEL_W'(BYTES_PER_WORD - 1)) state_d = ST_COLLECT;
        end
        if (last_byte) begin
          state_d = ST_RESPOND;
          data_d  = fill_word;
          fill    = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (last_byte) begin
          state_d = ST_RESPOND;
          data_d  = fill_word;
          fill    = 1'b1;
        end
      end
      ST_RESPOND: begin
        k_d  = '0;
        rx_d = '0;
        if (buf_full || accept) begin
          state_d = hit ? ST_RESPOND : ST_ISSUE;
          if (hit) data_d = hit_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      rx_q    <= '0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rx_q    <= rx_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

  assign waitrequest = buf_full;
  assign valid       = (state_q == ST_RESPOND);
  assign flash_data  = data_q;
  assign mem_rd      = (state_q == ST_ISSUE);
  assign mem_addr    = mem_rd ? {head_addr, k_q} : '0;

endmodule

// File: tb/tb_flash_responder.sv
// Scoreboard bench for flash_responder with a behavioural byte memory.
module tb_flash_responder;

  localparam int AW = 23;

`ifdef FLASH_RESP_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          read;
  logic [AW-1:0] address;
  logic          waitrequest;
  logic          valid;
  logic [31:0]   flash_data;
  logic          mem_rd;
  logic [AW+1:0] mem_addr;
  logic          mem_wait = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic          mem_rvalid = 1'b0;
  logic          cache_flush;

  always #5 clk = ~clk;

  flash_responder #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .read        (read),
    .address     (address),
    .waitrequest (waitrequest),
    .valid       (valid),
    .flash_data  (flash_data),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_wait    (mem_wait),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .cache_flush (cache_flush)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [AW+1:0] a);
    logic [7:0] n;
    if (a[AW+1:2] == AW'(32'h10)) begin
      n = {6'd0, a[1:0]} + 8'd1;
      return n * 8'h11;
    end
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mword(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = mbyte({a, 2'(j)});
    return w;
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
    bit            hit;
    int            due;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rsp_t;

  exp_t          sb[$];
  logic [AW+1:0] sq[$];
  rsp_t          mq[$];

  int cyc = 0;
  int lat = 2;
  int stall = 0;
  int rv_total = 0;
  int last_rv = 0;
  int rd_cycles = 0;
  int valid_cnt = 0;
  int first_due = -1;
  bit mvld = 1'b0;
  logic [AW-1:0] maddr = '0;

  always @(posedge clk) cyc++;

  // Byte memory: in-order responses 'lat' cycles after each taken strobe.
  always @(posedge clk) begin
    rsp_t r;
    #1;
    if (rst) begin
      mq.delete();
      mem_rvalid = 1'b0;
      mem_wait   = 1'b0;
      mem_rdata  = 8'h00;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
      if (mq.size() > 0 && mq[0].due == cyc + 1) begin
        r = mq.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = r.data;
      end
      mem_wait = 1'b0;
      if (mem_rd && mem_addr[1:0] == 2'd2 && stall > 0) begin
        mem_wait = 1'b1;
        stall--;
      end
      if (mem_rd && !mem_wait) mq.push_back('{mbyte(mem_addr), cyc + 1 + lat});
    end
  end

  // Monitor: accepts push expectations, strobes and valids are checked.
  always @(negedge clk) begin
    exp_t e;
    logic [AW+1:0] sa;
    bit hit;
    if (rst) begin
      sb.delete();
      sq.delete();
      mvld = 1'b0;
      first_due = -1;
    end else begin
      if (read && !waitrequest) begin
        hit = CACHE_ON && mvld && (maddr == address) && !cache_flush;
        e.addr = address;
        e.word = mword(address);
        e.hit  = hit;
        e.due  = (hit && sb.size() == 0) ? cyc + 1 : -1;
        if (!hit) begin
          for (int k = 0; k < 4; k++) sq.push_back({address, 2'(k)});
          if (sb.size() == 0) first_due = cyc + 1;
        end
        sb.push_back(e);
        maddr = address;
        mvld  = 1'b1;
      end else if (cache_flush) begin
        mvld = 1'b0;
      end
      if (mem_rd) rd_cycles++;
      if (mem_rd && !mem_wait) begin
        check_eq("strobe_queued", sq.size() > 0, 1);
        if (sq.size() > 0) begin
          sa = sq.pop_front();
          check_eq("strobe_addr", mem_addr, sa);
          if (sa[1:0] == 2'd0 && first_due >= 0) begin
            check_eq("first_strobe_cyc", cyc, first_due);
            first_due = -1;
          end
        end
      end
      if (mem_rvalid) begin
        rv_total++;
        last_rv = cyc;
      end
      if (valid) begin
        valid_cnt++;
        check_eq("valid_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("flash_data", flash_data, e.word);
          if (e.hit) begin
            if (e.due >= 0) check_eq("hit_latency", cyc, e.due);
          end else begin
            check_eq("miss_latency", cyc, last_rv + 1);
          end
          if (sb.size() > 0 && !sb[0].hit) first_due = cyc + 1;
        end
      end
    end
  end

  task automatic do_read(input logic [AW-1:0] a, output int waited);
    bit acc;
    read    = 1'b1;
    address = a;
    waited  = 0;
    forever begin
      @(negedge clk);
      acc = !waitrequest;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        check_eq("accept_timeout", waited, 0);
        break;
      end
    end
    read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && (sb.size() != 0 || sq.size() != 0 || mq.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_drained"}, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(input int target);
    for (int i = 0; i < 400 && rv_total < target; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("rv_reached", rv_total >= target, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    check_eq({tag, "_waitrequest"}, waitrequest, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_flash_data"}, flash_data, 0);
    check_eq({tag, "_mem_rd"}, mem_rd, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  initial begin
    int w;
    int snap;
    rst = 1'b1;
    read = 1'b0;
    address = '0;
    cache_flush = 1'b0;
    repeat (2) @(posedge clk);
    check_outputs_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word with latency 2: bytes 11,22,33,44 at 0x40..0x43.
    lat = 2;
    snap = rd_cycles;
    do_read(23'h10, w);
    wait_idle("s1");
    check_eq("s1_rd_cycles", rd_cycles - snap, 4);

    // Back-to-back: second held during first is taken, third waits.
    do_read(23'h1, w);
    do_read(23'h2, w);
    check_eq("s2_second_wait", w, 0);
    do_read(23'h3, w);
    check_eq("s2_third_stalled", w > 0, 1);
    wait_idle("s2");

    // Accept in the RESPOND cycle is served without an IDLE gap.
    snap = rv_total;
    do_read(23'h40, w);
    wait_rv(snap + 4);
    do_read(23'h41, w);
    check_eq("s24_respond_accept_wait", w, 0);
    wait_idle("s24");

    // Memory stall for three cycles at k=2.
    stall = 3;
    snap = rd_cycles;
    do_read(23'h20, w);
    wait_idle("s3");
    check_eq("s3_rd_cycles", rd_cycles - snap, 7);

    // Repeat read of 0x5, then with a flush between, then flush at accept.
    do_read(23'h5, w);
    wait_idle("c1");
    snap = rd_cycles;
    do_read(23'h5, w);
    wait_idle("c2");
    check_eq("c2_rd_cycles", rd_cycles - snap, CACHE_ON ? 0 : 4);
    cache_flush = 1'b1;
    @(posedge clk);
    #1;
    cache_flush = 1'b0;
    snap = rd_cycles;
    do_read(23'h5, w);
    wait_idle("c3");
    check_eq("c3_rd_cycles", rd_cycles - snap, 4);
    cache_flush = 1'b1;
    snap = rd_cycles;
    do_read(23'h5, w);
    cache_flush = 1'b0;
    wait_idle("c4");
    check_eq("c4_rd_cycles", rd_cycles - snap, 4);

    // Reset mid-word after two bytes: no response, then a clean read.
    lat = 2;
    snap = rv_total;
    do_read(23'h30, w);
    wait_rv(snap + 2);
    rst = 1'b1;
    check_outputs_zero("midrst");
    snap = valid_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check_eq("midrst_no_valid", valid_cnt - snap, 0);
    do_read(23'h7, w);
    wait_idle("s5");

    // Mixed latencies with back-to-back pairs.
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, 3);
      do_read(AW'($urandom_range(0, 32'h7FFFFF)), w);
      do_read(AW'($urandom_range(0, 32'h7FFFFF)), w);
      wait_idle("rnd");
    end

    check_eq("final_strobes_left", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
